// File: rtl/alu_pkg.sv
// Shared types and sizing helpers for the ALU-side sequential divider.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } div_state_t;

  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  localparam int unsigned DIV_CNT_W = cnt_width(4);

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, then subtract the divisor if it fits.
module div_step #(
  parameter int unsigned N = 4
) (
  input  logic [N:0]   pr,
  input  logic [N-1:0] dq,
  input  logic [N-1:0] b,
  output logic [N:0]   pr_next,
  output logic [N-1:0] dq_next
);

  logic [N+1:0] pr_sh;
  logic [N+1:0] diff;

  // The borrow out of the widened subtract doubles as the pr >= b compare.
  always_comb begin
    pr_sh = {pr, dq[N-1]};
    diff  = pr_sh - {2'b00, b};
    if (!diff[N+1]) begin
      pr_next = diff[N:0];
      dq_next = {dq[N-2:0], 1'b1};
    end else begin
      pr_next = pr_sh[N:0];
      dq_next = {dq[N-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider producing one quotient bit per clock,
// with a one-cycle done pulse and a divide-by-zero flag.
module seq_divider
  import alu_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int unsigned CW = cnt_width(N);

  div_state_t    state, state_nxt;
  logic [CW-1:0] cnt;
  logic [N:0]    pr, pr_nxt;
  logic [N-1:0]  dq, dq_nxt;
  logic [N-1:0]  b_r;
  logic          accept;
  logic          last_step;

  div_step #(.N(N)) u_step (
    .pr      (pr),
    .dq      (dq),
    .b       (b_r),
    .pr_next (pr_nxt),
    .dq_next (dq_nxt)
  );

  always_comb begin
    accept    = start && (state != RUN);
    last_step = (state == RUN) && (cnt == CW'(1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: begin
        if (start) state_nxt = (b != '0) ? RUN : DONE;
        else       state_nxt = IDLE;
      end
      RUN:     state_nxt = (cnt == CW'(1)) ? DONE : RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt         <= '0;
      pr          <= '0;
      dq          <= '0;
      b_r         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      if (b != '0) begin
        dq  <= a;
        b_r <= b;
        pr  <= '0;
        cnt <= CW'(N);
      end else begin
        quotient    <= '1;
        remainder   <= a;
        div_by_zero <= 1'b1;
      end
    end else if (state == RUN) begin
      pr  <= pr_nxt;
      dq  <= dq_nxt;
      cnt <= cnt - CW'(1);
      // Result registers take the step outputs directly so done lines up with valid data.
      if (last_step) begin
        quotient    <= dq_nxt;
        remainder   <= pr_nxt[N-1:0];
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (N=4): arithmetic reference model plus
// directed vectors with literal expectations.
module tb_seq_divider;

  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [N-1:0] a, b;
  logic         busy, done, div_by_zero;
  logic [N-1:0] quotient, remainder;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  seq_divider #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: cycles left until the result, and the result by plain / and %.
  int           m_left = 0;
  logic         m_done = 1'b0;
  logic         m_dbz  = 1'b0;
  logic [N-1:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_left = 0; m_done = 1'b0; m_q = '0; m_r = '0; m_dbz = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left != 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1'b1; m_q = p_q; m_r = p_r; m_dbz = 1'b0;
        end
      end else if (start) begin
        if (b == 0) begin
          m_done = 1'b1; m_q = '1; m_r = a; m_dbz = 1'b1;
        end else begin
          m_left = N; p_q = a / b; p_r = a % b;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",        busy,        m_left != 0);
      check("done",        done,        m_done);
      check("quotient",    quotient,    m_q);
      check("remainder",   remainder,   m_r);
      check("div_by_zero", div_by_zero, m_dbz);
      check("busy_and_done_exclusive", busy & done, 1'b0);
    end
  end

  task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb_v,
                        input logic [N-1:0] eq, input logic [N-1:0] er,
                        input logic edz, input int lat, input string tag);
    int cyc;
    bit saw_busy;
    @(posedge clk); #1;
    a = ta; b = tb_v; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; saw_busy = 1'b0;
    do begin
      @(negedge clk);
      cyc++;
      if (busy) saw_busy = 1'b1;
    end while (!done && cyc < 20);
    check({tag, "_latency"}, cyc, lat);
    check({tag, "_q"}, quotient, eq);
    check({tag, "_r"}, remainder, er);
    check({tag, "_dbz"}, div_by_zero, edz);
    check({tag, "_busy_seen"}, saw_busy, lat > 1);
  endtask

  typedef struct {
    logic [N-1:0] ta, tb_v, eq, er;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    vecs[0] = '{4'd0,  4'd5,  4'd0, 4'd0};
    vecs[1] = '{4'd14, 4'd15, 4'd0, 4'd14};
    vecs[2] = '{4'd15, 4'd15, 4'd1, 4'd0};
    vecs[3] = '{4'd8,  4'd9,  4'd0, 4'd8};
    vecs[4] = '{4'd15, 4'd2,  4'd7, 4'd1};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_q", quotient, 4'd0);
    check("reset_r", remainder, 4'd0);
    check("reset_dbz", div_by_zero, 1'b0);

    run_op(4'd13, 4'd3, 4'd4,  4'd1, 1'b0, 5, "div13_3");
    run_op(4'd7,  4'd0, 4'd15, 4'd7, 1'b1, 1, "div7_0");

    // Back-to-back: second start presented during the done cycle of the first.
    run_op(4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 5, "div15_1");
    a = 4'd2; b = 4'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (!done) begin
        check("b2b_hold_q", quotient, 4'd15);
        check("b2b_hold_r", remainder, 4'd0);
      end
    end while (!done && cyc < 20);
    check("b2b_latency", cyc, 5);
    check("b2b_q", quotient, 4'd0);
    check("b2b_r", remainder, 4'd2);

    // Start and operand changes while busy must be ignored.
    @(posedge clk); #1;
    a = 4'd9; b = 4'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    @(negedge clk); cyc++;
    @(posedge clk); #1;
    a = 4'd6; b = 4'd3; start = 1'b1;
    @(negedge clk); cyc++;
    @(posedge clk); #1;
    start = 1'b0; a = 4'd15; b = 4'd0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done && cyc < 20);
    check("ignore_latency", cyc, 5);
    check("ignore_q", quotient, 4'd4);
    check("ignore_r", remainder, 4'd1);
    check("ignore_dbz", div_by_zero, 1'b0);

    // Reset asserted in the second busy cycle aborts the operation.
    @(posedge clk); #1;
    a = 4'd14; b = 4'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy_before_edge", busy, 1'b1);
    @(negedge clk);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_q", quotient, 4'd0);
    check("abort_r", remainder, 4'd0);
    check("abort_dbz", div_by_zero, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("abort_no_done", done, 1'b0);
    end

    foreach (vecs[i])
      run_op(vecs[i].ta, vecs[i].tb_v, vecs[i].eq, vecs[i].er, 1'b0, 5, $sformatf("vec%0d", i));

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
